// File: rtl/drop_sequencer.sv
// drop_sequencer
//   Times a "drop window". start opens the window (TIMING) and t_act counts
//   up in 8.8 fixed point (1 LSB = 1/256 s) from a tick_frac time base
//   divided by TICK_DIV. When t_act reaches t_lim the window moves to
//   EXPIRED and t_act freezes. abort returns to IDLE from any state.
//
// Parameters
//   LIM_RESET  limit loaded into t_lim at reset (8.8 fixed point)
//   TICK_DIV   tick_frac pulses per t_act LSB
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset, highest priority
//   tick_frac  single-cycle time-base pulse
//   start      begin (or restart from EXPIRED) a drop window
//   abort      cancel and return to IDLE; wins over start
//   lim_load   write strobe for lim_value, honoured only in IDLE
//   lim_value  new limit, 8.8 fixed point
//   t_act      elapsed time, registered
//   t_lim      active limit, registered
//   drop_en    drop window enabled (TIMING or EXPIRED), registered
//   busy       high in TIMING, registered
//   expired    high in EXPIRED, registered
//   state_dbg  current FSM state (0 IDLE, 1 TIMING, 2 EXPIRED)
//
// Handshake: start/abort/lim_load/tick_frac are single-cycle strobes sampled
// on the rising edge; there is no back-pressure, every strobe is either
// acted on in that cycle or dropped according to the current state.
//
// Build option
//   DROP_SEQ_AUTO_IDLE_EN  when defined, EXPIRED falls back to IDLE after
//                          256 tick_frac pulses, clearing t_act.

module drop_sequencer #(
  parameter logic [15:0] LIM_RESET = 16'h0A00,
  parameter int          TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_frac,
  input  logic        start,
  input  logic        abort,
  input  logic        lim_load,
  input  logic [15:0] lim_value,
  output logic [15:0] t_act,
  output logic [15:0] t_lim,
  output logic        drop_en,
  output logic        busy,
  output logic        expired,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_TIMING  = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [1:0]       state, state_nx;
  logic [15:0]      t_act_nx, t_lim_nx;
  logic [DIV_W-1:0] div_cnt, div_nx;

`ifdef DROP_SEQ_AUTO_IDLE_EN
  logic [7:0] idle_cnt, idle_cnt_nx;
`endif

  always_comb begin
    state_nx = state;
    t_act_nx = t_act;
    div_nx   = div_cnt;
    t_lim_nx = t_lim;
`ifdef DROP_SEQ_AUTO_IDLE_EN
    idle_cnt_nx = idle_cnt;
`endif

    case (state)
      ST_IDLE: begin
        t_act_nx = 16'h0000;
        div_nx   = '0;
        if (start) state_nx = ST_TIMING;
      end

      ST_TIMING: begin
        // Limit check uses the registered t_act and suppresses any
        // coincident tick, so t_act never overshoots the limit.
        if (t_act >= t_lim) begin
          state_nx = ST_EXPIRED;
`ifdef DROP_SEQ_AUTO_IDLE_EN
          idle_cnt_nx = 8'd0;
`endif
        end else if (tick_frac) begin
          if (div_cnt == DIV_LAST) begin
            div_nx = '0;
            if (t_act != 16'hFFFF) t_act_nx = t_act + 16'd1;
          end else begin
            div_nx = div_cnt + DIV_W'(1);
          end
        end
      end

      ST_EXPIRED: begin
        if (start) begin
          state_nx = ST_TIMING;
          t_act_nx = 16'h0000;
          div_nx   = '0;
        end
`ifdef DROP_SEQ_AUTO_IDLE_EN
        else if (tick_frac) begin
          if (idle_cnt == 8'd255) begin
            state_nx = ST_IDLE;
            t_act_nx = 16'h0000;
          end else begin
            idle_cnt_nx = idle_cnt + 8'd1;
          end
        end
`endif
      end

      default: begin
        state_nx = ST_IDLE;
        t_act_nx = 16'h0000;
        div_nx   = '0;
      end
    endcase

    // The limit only changes while idle, so a running window always sees a
    // stable t_lim; loading together with start applies to the new window.
    if (state == ST_IDLE && lim_load) t_lim_nx = lim_value;

    if (abort) begin
      state_nx = ST_IDLE;
      t_act_nx = 16'h0000;
      div_nx   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      t_act   <= 16'h0000;
      t_lim   <= LIM_RESET;
      div_cnt <= '0;
      drop_en <= 1'b0;
      busy    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_nx;
      t_act   <= t_act_nx;
      t_lim   <= t_lim_nx;
      div_cnt <= div_nx;
      // Flags are decoded from the next state so they line up with state.
      drop_en <= (state_nx != ST_IDLE);
      busy    <= (state_nx == ST_TIMING);
      expired <= (state_nx == ST_EXPIRED);
    end
  end

`ifdef DROP_SEQ_AUTO_IDLE_EN
  always_ff @(posedge clk) begin
    if (rst) idle_cnt <= 8'd0;
    else     idle_cnt <= idle_cnt_nx;
  end
`endif

  assign state_dbg = state;

endmodule

// File: doc/drop_sequencer.md
DROP_SEQUENCER -- requirements
Module: drop_sequencer

Interface
REQ-001 Parameter LIM_RESET, default 16'h0A00, 8.8 fixed-point time limit loaded at reset (10.0 s).
REQ-002 Parameter TICK_DIV, default 1, number of tick_frac pulses per t_act LSB (1 LSB = 1/256 s).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tick_frac  input  1  single-cycle time-base pulse.
REQ-006 start  input  1  single-cycle request to begin a drop window.
REQ-007 abort  input  1  single-cycle request to cancel and return to idle.
REQ-008 lim_load  input  1  write strobe for lim_value.
REQ-009 lim_value  input  16  new limit, 8.8 fixed point.
REQ-010 t_act  output  16  elapsed time, 8.8 fixed point, registered.
REQ-011 t_lim  output  16  active limit, 8.8 fixed point, registered.
REQ-012 drop_en  output  1  drop window enabled, registered.
REQ-013 busy  output  1  high in TIMING.
REQ-014 expired  output  1  high in EXPIRED.

Function
REQ-015 FSM states SHALL be IDLE, TIMING and EXPIRED; encoding is free.
REQ-016 IDLE: drop_en=0, t_act=0; start -> TIMING next cycle, with t_act cleared and the tick divider cleared.
REQ-017 TIMING: drop_en=1; t_act increments by 1 on every TICK_DIV-th tick_frac, saturating at 16'hFFFF (no wrap).
REQ-018 TIMING: when registered t_act >= t_lim (unsigned 16-bit compare), next state SHALL be EXPIRED and t_act SHALL NOT increment that cycle, even with a coincident tick.
REQ-019 EXPIRED: drop_en=1, t_act frozen; start -> TIMING with t_act cleared; ticks ignored.
REQ-020 abort in any state -> IDLE next cycle, t_act=0, drop_en=0; abort SHALL win over a simultaneous start.
REQ-021 start in TIMING SHALL be ignored.
REQ-022 lim_load SHALL update t_lim next cycle only in IDLE and is ignored in TIMING/EXPIRED; lim_load coincident with start in IDLE SHALL load t_lim and start, and the new limit applies to that window.
REQ-023 t_lim=0 SHALL cause TIMING -> EXPIRED after exactly one cycle with t_act=0.
REQ-024 All outputs SHALL be registered; the busy/expired/drop_en latency from a start or abort edge is one clock.

Reset
REQ-025 On rst=1 at a clock edge: state=IDLE, t_act=0, t_lim=LIM_RESET, drop_en=0, busy=0, expired=0, tick divider=0.
REQ-026 rst SHALL take priority over every other input, including mid-window (TIMING/EXPIRED).

Configuration
REQ-027 Macro DROP_SEQ_AUTO_IDLE_EN: when defined, EXPIRED SHALL return to IDLE automatically after 256 tick_frac pulses (an 8-bit counter cleared on EXPIRED entry), with t_act cleared on that transition; when undefined, EXPIRED SHALL persist until start, abort or rst.

Verification
REQ-028 rst, lim_load with lim_value=16'h0003 in IDLE, start, TICK_DIV=1, tick every cycle -> t_act 0,1,2,3; EXPIRED one cycle after t_act=3; drop_en=1 throughout; t_act stays at 3.
REQ-029 In TIMING at t_act=16'h0102, assert abort and start together -> IDLE next cycle, t_act=0, drop_en=0, busy=0.
REQ-030 t_lim=16'hFFFF, force t_act near 16'hFFFE, tick continuously -> t_act reaches 16'hFFFF, EXPIRED, no wrap to 0.
REQ-031 lim_load with 16'h0500 while in TIMING -> t_lim unchanged (LIM_RESET); after abort, the same lim_load -> t_lim=16'h0500.
REQ-032 Assert rst while in EXPIRED with t_act=16'h0A00 -> all outputs at reset values next cycle; t_lim=16'h0A00.
REQ-033 With DROP_SEQ_AUTO_IDLE_EN defined, enter EXPIRED and apply 256 ticks -> IDLE after the 256th tick, drop_en=0; without the macro -> still EXPIRED.
